// File: rtl/axi_ram_slave_if.sv
// AXI-style burst bus between a memory master and axi_ram_slave.
// A beat transfers on any rising clk edge where valid and ready are both 1.
// valid never waits for ready, and payload is held while valid is 1 and ready is 0.
interface axi_ram_slave_if;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [3:0]  m_axi_awlen;

  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;

  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;

  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;

  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic [1:0]  m_axi_rresp;

  modport slave (
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
    input  m_axi_rready
  );

  modport master (
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
    output m_axi_rready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// 64-bit INCR-burst RAM slave with independent write and read FSMs.
// Define AXI_RAM_RANDOM_STALL_EN to add LFSR-driven backpressure on the ready/valid outputs.
module axi_ram_slave #(
  parameter logic [31:0] MEM_BASE       = 32'h2000_0000,
  parameter int          MEM_WORDS_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_ram_slave_if.slave   axi,
  output logic [1:0]       dbg_wr_state_o,
  output logic             dbg_rd_state_o
);
  localparam int AW = MEM_WORDS_BITS;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  logic [63:0] mem [0:(2**AW)-1];

  logic stall;
`ifdef AXI_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Holds the address-channel readies low until the first edge after reset release.
  logic live_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  logic [AW-1:0] aw_idx, ar_idx;
  assign aw_idx = AW'((axi.m_axi_awaddr - MEM_BASE) >> 3);
  assign ar_idx = AW'((axi.m_axi_araddr - MEM_BASE) >> 3);

  // ---------------- write path ----------------
  wr_state_e     wr_state_q, wr_state_d;
  logic [AW-1:0] waddr_q;
  logic [3:0]    wlen_q;
  logic [4:0]    wcnt_q;
  logic [1:0]    bresp_q;
  logic          aw_hs, w_hs, b_hs, w_keep;

  assign axi.m_axi_awready = live_q & ~stall & (wr_state_q == W_IDLE);
  assign axi.m_axi_wready  = ~stall & (wr_state_q == W_DATA);
  assign axi.m_axi_bvalid  = (wr_state_q == W_RESP);
  assign axi.m_axi_bresp   = bresp_q;

  assign aw_hs  = axi.m_axi_awvalid & axi.m_axi_awready;
  assign w_hs   = axi.m_axi_wvalid & axi.m_axi_wready;
  assign b_hs   = axi.m_axi_bvalid & axi.m_axi_bready;
  assign w_keep = (wcnt_q <= {1'b0, wlen_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state_q <= W_IDLE;
    else        wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (aw_hs) wr_state_d = W_DATA;
      W_DATA:  if (w_hs && axi.m_axi_wlast) wr_state_d = W_RESP;
      W_RESP:  if (b_hs) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // wcnt_q saturates at 16 so an over-long burst still reports SLVERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      wlen_q  <= '0;
      wcnt_q  <= '0;
      bresp_q <= 2'b00;
    end else if (aw_hs) begin
      waddr_q <= aw_idx;
      wlen_q  <= axi.m_axi_awlen;
      wcnt_q  <= '0;
    end else if (w_hs) begin
      if (w_keep) waddr_q <= waddr_q + 1'b1;
      if (wcnt_q != 5'd16) wcnt_q <= wcnt_q + 5'd1;
      if (axi.m_axi_wlast) bresp_q <= (wcnt_q == {1'b0, wlen_q}) ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_keep) begin
      for (int b = 0; b < 8; b++) begin
        if (axi.m_axi_wstrb[b]) mem[waddr_q][8*b +: 8] <= axi.m_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e     rd_state_q, rd_state_d;
  logic [AW-1:0] raddr_q, raddr_nxt;
  logic [3:0]    rlen_q, rcnt_q, rcnt_nxt;
  logic          rvalid_q, rlast_q;
  logic [63:0]   rdata_q;
  logic          ar_hs, r_hs;

  assign axi.m_axi_arready = live_q & ~stall & (rd_state_q == R_IDLE);
  assign axi.m_axi_rvalid  = rvalid_q;
  assign axi.m_axi_rlast   = rlast_q;
  assign axi.m_axi_rdata   = rdata_q;
  assign axi.m_axi_rresp   = 2'b00;

  assign ar_hs     = axi.m_axi_arvalid & axi.m_axi_arready;
  assign r_hs      = rvalid_q & axi.m_axi_rready;
  assign raddr_nxt = raddr_q + 1'b1;
  assign rcnt_nxt  = rcnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state_q <= R_IDLE;
    else        rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Memory is sampled at the handshake edge, so a same-edge write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      raddr_q  <= ar_idx;
      rlen_q   <= axi.m_axi_arlen;
      rcnt_q   <= '0;
      rdata_q  <= mem[ar_idx];
      rvalid_q <= 1'b1;
      rlast_q  <= (axi.m_axi_arlen == 4'd0);
    end else if (r_hs) begin
      if (rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else begin
        raddr_q  <= raddr_nxt;
        rdata_q  <= mem[raddr_nxt];
        rcnt_q   <= rcnt_nxt;
        rlast_q  <= (rcnt_nxt == rlen_q);
        rvalid_q <= ~stall;
      end
    end else if (rd_state_q == R_DATA && !rvalid_q && !stall) begin
      rvalid_q <= 1'b1;
    end
  end

  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave: bursts, strobes, SLVERR, stalls, wrap, reset.
module tb_axi_ram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_ram_slave_if axi();
  logic [1:0] dbg_wr;
  logic       dbg_rd;

  axi_ram_slave dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axi           (axi),
    .dbg_wr_state_o(dbg_wr),
    .dbg_rd_state_o(dbg_rd)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] wd[16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [3:0] len);
    @(negedge clk);
    axi.m_axi_awvalid = 1'b1;
    axi.m_axi_awaddr  = addr;
    axi.m_axi_awlen   = len;
    for (int i = 0; i < 20; i++) begin
      if (axi.m_axi_awready) break;
      @(negedge clk);
    end
    check("aw_accept", {63'd0, axi.m_axi_awready}, 64'd1);
    @(posedge clk);
    #1 axi.m_axi_awvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input int nbeats,
                             input logic [7:0] strb, input bit hold, input logic [1:0] exp_resp);
    aw_send(addr, len);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      axi.m_axi_wvalid = 1'b1;
      axi.m_axi_wdata  = wd[i];
      axi.m_axi_wstrb  = strb;
      axi.m_axi_wlast  = (i == nbeats - 1);
      if (i == 0) check("aw_busy", {63'd0, axi.m_axi_awready}, 64'd0);
      for (int t = 0; t < 20; t++) begin
        if (axi.m_axi_wready) break;
        @(negedge clk);
      end
      check("w_accept", {63'd0, axi.m_axi_wready}, 64'd1);
      @(posedge clk);
      #1;
    end
    axi.m_axi_wvalid = 1'b0;
    axi.m_axi_wlast  = 1'b0;
    @(negedge clk);
    check("b_valid", {63'd0, axi.m_axi_bvalid}, 64'd1);
    check("b_resp", {62'd0, axi.m_axi_bresp}, {62'd0, exp_resp});
    if (hold) begin
      @(negedge clk);
      check("b_hold_valid", {63'd0, axi.m_axi_bvalid}, 64'd1);
      check("b_hold_resp", {62'd0, axi.m_axi_bresp}, {62'd0, exp_resp});
    end
    axi.m_axi_bready = 1'b1;
    @(posedge clk);
    #1 axi.m_axi_bready = 1'b0;
    @(negedge clk);
    check("b_done", {63'd0, axi.m_axi_bvalid}, 64'd0);
    check("aw_back", {63'd0, axi.m_axi_awready}, 64'd1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input bit toggle);
    logic [63:0] d;
    logic        l;
    logic [63:0] e;
    @(negedge clk);
    axi.m_axi_arvalid = 1'b1;
    axi.m_axi_araddr  = addr;
    axi.m_axi_arlen   = len;
    for (int i = 0; i < 20; i++) begin
      if (axi.m_axi_arready) break;
      @(negedge clk);
    end
    check("ar_accept", {63'd0, axi.m_axi_arready}, 64'd1);
    @(posedge clk);
    #1 axi.m_axi_arvalid = 1'b0;
    @(negedge clk);
    check("r_first", {63'd0, axi.m_axi_rvalid}, 64'd1);
    check("ar_busy", {63'd0, axi.m_axi_arready}, 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      if (toggle && (i % 2 == 0)) begin
        axi.m_axi_rready = 1'b0;
        d = axi.m_axi_rdata;
        l = axi.m_axi_rlast;
        @(negedge clk);
        check("r_stall_valid", {63'd0, axi.m_axi_rvalid}, 64'd1);
        check("r_stall_data", axi.m_axi_rdata, d);
        check("r_stall_last", {63'd0, axi.m_axi_rlast}, {63'd0, l});
      end
      axi.m_axi_rready = 1'b1;
      check("r_valid", {63'd0, axi.m_axi_rvalid}, 64'd1);
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("r_data", axi.m_axi_rdata, e);
      end
      check("r_last", {63'd0, axi.m_axi_rlast}, {63'd0, (i == int'(len))});
      @(posedge clk);
      #1 axi.m_axi_rready = 1'b0;
      @(negedge clk);
    end
    check("r_done", {63'd0, axi.m_axi_rvalid}, 64'd0);
    check("ar_back", {63'd0, axi.m_axi_arready}, 64'd1);
  endtask

  initial begin
    axi.m_axi_awvalid = 1'b0; axi.m_axi_awaddr = '0; axi.m_axi_awlen = '0;
    axi.m_axi_wvalid  = 1'b0; axi.m_axi_wdata  = '0; axi.m_axi_wstrb = '0; axi.m_axi_wlast = 1'b0;
    axi.m_axi_bready  = 1'b0;
    axi.m_axi_arvalid = 1'b0; axi.m_axi_araddr = '0; axi.m_axi_arlen = '0;
    axi.m_axi_rready  = 1'b0;

    // Reset state
    #12;
    check("rst_awready", {63'd0, axi.m_axi_awready}, 64'd0);
    check("rst_arready", {63'd0, axi.m_axi_arready}, 64'd0);
    check("rst_wready", {63'd0, axi.m_axi_wready}, 64'd0);
    check("rst_bvalid", {63'd0, axi.m_axi_bvalid}, 64'd0);
    check("rst_rvalid", {63'd0, axi.m_axi_rvalid}, 64'd0);
    check("rst_rdata", axi.m_axi_rdata, 64'd0);
    check("rst_states", {61'd0, dbg_wr, dbg_rd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ar_pre", {63'd0, axi.m_axi_arready}, 64'd0);
    @(negedge clk);
    check("rel_ar", {63'd0, axi.m_axi_arready}, 64'd1);
    check("rel_aw", {63'd0, axi.m_axi_awready}, 64'd1);

    // Basic 4-beat write and read at word 0
    for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
    write_burst(32'h2000_0000, 4'd3, 4, 8'hFF, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(i + 1));
    read_burst(32'h2000_0000, 4'd3, 1'b0);

    // Partial strobe at word 0x20
    wd[0] = 64'h0;
    write_burst(32'h2000_0100, 4'd0, 1, 8'hFF, 1'b0, 2'b00);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(32'h2000_0100, 4'd0, 1, 8'h0F, 1'b0, 2'b00);
    exp_q.push_back(64'h0000_0000_FFFF_FFFF);
    read_burst(32'h2000_0100, 4'd0, 1'b0);

    // Early wlast -> SLVERR, B held while bready low; stalled reads
    wd[0] = 64'hA; wd[1] = 64'hB;
    write_burst(32'h2000_0200, 4'd3, 2, 8'hFF, 1'b1, 2'b10);
    exp_q.push_back(64'hA); exp_q.push_back(64'hB);
    read_burst(32'h2000_0200, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(i + 1));
    read_burst(32'h2000_0000, 4'd3, 1'b1);

    // Extra beat beyond awlen+1 is discarded and flagged
    wd[0] = 64'h0; wd[1] = 64'hE;
    write_burst(32'h2000_0280, 4'd1, 2, 8'hFF, 1'b0, 2'b00);
    wd[0] = 64'hC; wd[1] = 64'hD;
    write_burst(32'h2000_0280, 4'd0, 2, 8'hFF, 1'b0, 2'b10);
    exp_q.push_back(64'hC); exp_q.push_back(64'hE);
    read_burst(32'h2000_0280, 4'd1, 1'b0);

    // Same-edge write and read of word 0x60 returns the old word
    wd[0] = 64'hAAAA;
    write_burst(32'h2000_0300, 4'd0, 1, 8'hFF, 1'b0, 2'b00);
    aw_send(32'h2000_0300, 4'd0);
    @(negedge clk);
    axi.m_axi_wvalid = 1'b1; axi.m_axi_wdata = 64'hBBBB; axi.m_axi_wstrb = 8'hFF; axi.m_axi_wlast = 1'b1;
    axi.m_axi_arvalid = 1'b1; axi.m_axi_araddr = 32'h2000_0300; axi.m_axi_arlen = 4'd0;
    check("coll_rdy", {62'd0, axi.m_axi_wready, axi.m_axi_arready}, 64'd3);
    @(posedge clk);
    #1;
    axi.m_axi_wvalid = 1'b0; axi.m_axi_wlast = 1'b0; axi.m_axi_arvalid = 1'b0;
    @(negedge clk);
    check("coll_rvalid", {63'd0, axi.m_axi_rvalid}, 64'd1);
    check("coll_rd_old", axi.m_axi_rdata, 64'hAAAA);
    check("coll_bvalid", {63'd0, axi.m_axi_bvalid}, 64'd1);
    axi.m_axi_rready = 1'b1; axi.m_axi_bready = 1'b1;
    @(posedge clk);
    #1;
    axi.m_axi_rready = 1'b0; axi.m_axi_bready = 1'b0;
    exp_q.push_back(64'hBBBB);
    read_burst(32'h2000_0300, 4'd0, 1'b0);

    // Reset in the middle of a read burst
    @(negedge clk);
    axi.m_axi_arvalid = 1'b1; axi.m_axi_araddr = 32'h2000_0000; axi.m_axi_arlen = 4'd3;
    @(posedge clk);
    #1 axi.m_axi_arvalid = 1'b0;
    axi.m_axi_rready = 1'b1;
    @(negedge clk);
    check("mid_beat1", axi.m_axi_rdata, 64'd1);
    @(negedge clk);
    check("mid_beat2", axi.m_axi_rdata, 64'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", {63'd0, axi.m_axi_rvalid}, 64'd0);
    check("mid_rst_rlast", {63'd0, axi.m_axi_rlast}, 64'd0);
    check("mid_rst_rdata", axi.m_axi_rdata, 64'd0);
    check("mid_rst_rdy", {62'd0, axi.m_axi_arready, axi.m_axi_awready}, 64'd0);
    axi.m_axi_rready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_pre", {63'd0, axi.m_axi_arready}, 64'd0);
    @(negedge clk);
    check("mid_rel_ar", {63'd0, axi.m_axi_arready}, 64'd1);
    check("mid_rel_state", {63'd0, dbg_rd}, 64'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(i + 1));
    read_burst(32'h2000_0000, 4'd3, 1'b0);

    // Wrap from the last memory word to word 0
    wd[0] = 64'h1111; wd[1] = 64'h2222;
    write_burst(32'h2007_FFF8, 4'd1, 2, 8'hFF, 1'b0, 2'b00);
    exp_q.push_back(64'h1111); exp_q.push_back(64'h2222);
    read_burst(32'h2007_FFF8, 4'd1, 1'b0);
    exp_q.push_back(64'h2222);
    read_burst(32'h2000_0000, 4'd0, 1'b0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
